// File: rtl/adsr_pkg.sv
// Shared types and constants for the pulse front-end that feeds the ADSR pixel filter.
package adsr_pkg;

    typedef enum logic [1:0] {
        S_WAIT_RISE = 2'd0,
        S_HIGH      = 2'd1,
        S_DIVIDE    = 2'd2
    } state_t;

    localparam int MS_PER_MIN = 60000;

    // Shortest legal beat interval: anything faster is treated as a double detection.
    function automatic int refractory_ms(input int max_bpm);
        return MS_PER_MIN / max_bpm;
    endfunction

    // Longest legal beat interval: beyond this the pulse is considered lost.
    function automatic int timeout_ms(input int min_bpm);
        return MS_PER_MIN / min_bpm;
    endfunction

endpackage

// File: rtl/pulse_bpm_estimator_div.sv
// bpm_serial_div: 16-bit restoring divider, one quotient bit per cycle, 16-cycle latency,
// one-cycle done strobe. A start while busy is ignored.
module bpm_serial_div (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [15:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [15:0] quotient
);

    logic [15:0] rem_q, rem_d;
    logic [15:0] quo_q, quo_d;
    logic [15:0] dvs_q, dvs_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        done_q, done_d;
    logic [16:0] shifted;
    logic [16:0] diff;

    always_comb begin
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        shifted = {rem_q, quo_q[15]};
        diff    = shifted - {1'b0, dvs_q};
        if (start && cnt_q == 5'd0) begin
            rem_d = '0;
            quo_d = dividend;
            dvs_d = divisor;
            cnt_d = 5'd16;
        end else if (cnt_q != 5'd0) begin
            // The remainder stays below the divisor, so diff fits in 16 bits when taken.
            if (shifted >= {1'b0, dvs_q}) begin
                rem_d = diff[15:0];
                quo_d = {quo_q[14:0], 1'b1};
            end else begin
                rem_d = shifted[15:0];
                quo_d = {quo_q[14:0], 1'b0};
            end
            cnt_d  = cnt_q - 5'd1;
            done_d = (cnt_q == 5'd1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign busy     = (cnt_q != 5'd0);
    assign done     = done_q;
    assign quotient = quo_q;

endmodule

// File: rtl/pulse_bpm_estimator.sv
// Beat detector with adaptive hysteresis threshold, ms interval timer and BPM divider.
// Define BPM_SMOOTH_EN to blend each new BPM 1:3 with the previous estimate.
module pulse_bpm_estimator
    import adsr_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BITS        = 8,
    parameter int MIN_BPM     = 40,
    parameter int MAX_BPM     = 200,
    parameter int HYST        = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [BITS-1:0]                  sample_in,
    input  logic                             sample_valid,
    output logic [$clog2(MAX_BPM+1)-1:0]     BPM_estimate,
    output logic [BITS-1:0]                  pulse_amplitude,
    output logic                             bpm_valid,
    output logic                             beat_pulse,
    output state_t                           dbg_state,
    output logic                             dbg_armed,
    output logic [BITS-1:0]                  dbg_thr
);

    localparam int BW    = $clog2(MAX_BPM + 1);
    localparam int TICKS = CLK_FREQ_HZ / 1000;
    localparam int TW    = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam logic [TW-1:0]   TICK_LAST = TW'(TICKS - 1);
    localparam logic [10:0]     T_OUT     = 11'(timeout_ms(MIN_BPM));
    localparam logic [10:0]     T_REFR    = 11'(refractory_ms(MAX_BPM));
    localparam logic [BITS:0]   THR_SAT   = {1'b0, {BITS{1'b1}}};
    localparam logic [BITS-1:0] THR_MID   = BITS'(1 << (BITS - 1));
    localparam logic [BITS:0]   HYST_W    = (BITS + 1)'(HYST);
    localparam logic [BW-1:0]   MIN_Q     = BW'(MIN_BPM);
    localparam logic [BW-1:0]   MAX_Q     = BW'(MAX_BPM);

    state_t          state_q, state_d;
    logic [BITS-1:0] thr_q, thr_d, max_q, max_d, min_q, min_d, amp_q, amp_d;
    logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
    logic [10:0]     interval_q, interval_d;
    logic [BW-1:0]   bpm_q, bpm_d, bpm_raw, bpm_new;
    logic            armed_q, armed_d, bpm_valid_q, bpm_valid_d, beat_q, beat_d;
    logic            tick, timeout, rise, fall, div_start, div_busy, div_done;
    logic [BITS:0]   thr_hi_raw, thr_hi, thr_lo, mid_sum;
    logic [BITS-1:0] mx_cur, mn_cur;
    logic [15:0]     div_quo;

    bpm_serial_div u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend (16'(MS_PER_MIN)),
        .divisor  ({5'b0, interval_q}),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quo)
    );

    always_comb begin
        bpm_raw = (div_quo < 16'(MIN_BPM)) ? MIN_Q :
                  (div_quo > 16'(MAX_BPM)) ? MAX_Q : div_quo[BW-1:0];
    end

`ifdef BPM_SMOOTH_EN
    logic [9:0] bpm_smooth;
    assign bpm_smooth = (10'(bpm_q) * 10'd3 + 10'(bpm_raw) + 10'd2) >> 2;
    assign bpm_new    = bpm_valid_q ? BW'(bpm_smooth) : bpm_raw;
`else
    assign bpm_new = bpm_raw;
`endif

    // Datapath terms shared by the next-state logic.
    always_comb begin
        tick       = (tick_cnt_q == TICK_LAST);
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        thr_hi_raw = {1'b0, thr_q} + HYST_W;
        thr_hi     = (thr_hi_raw > THR_SAT) ? THR_SAT : thr_hi_raw;
        thr_lo     = ({1'b0, thr_q} >= HYST_W) ? ({1'b0, thr_q} - HYST_W) : '0;
        rise       = sample_valid && ({1'b0, sample_in} > thr_hi);
        fall       = sample_valid && ({1'b0, sample_in} < thr_lo);
        mx_cur     = (sample_valid && sample_in > max_q) ? sample_in : max_q;
        mn_cur     = (sample_valid && sample_in < min_q) ? sample_in : min_q;
        mid_sum    = {1'b0, mx_cur} + {1'b0, mn_cur};
        timeout    = tick && (interval_q == T_OUT - 11'd1) && (state_q != S_DIVIDE);
    end

    always_comb begin
        state_d     = state_q;
        thr_d       = thr_q;
        armed_d     = armed_q;
        max_d       = mx_cur;
        min_d       = mn_cur;
        amp_d       = amp_q;
        bpm_d       = bpm_q;
        bpm_valid_d = bpm_valid_q;
        beat_d      = 1'b0;
        div_start   = 1'b0;
        interval_d  = (tick && interval_q != T_OUT) ? interval_q + 11'd1 : interval_q;
        if (timeout) begin
            bpm_d       = '0;
            amp_d       = '0;
            bpm_valid_d = 1'b0;
            armed_d     = 1'b0;
            thr_d       = THR_MID;
            state_d     = S_WAIT_RISE;
        end else begin
            case (state_q)
                S_WAIT_RISE: begin
                    if (rise) begin
                        if (interval_q < T_REFR) begin
                            state_d = S_HIGH;
                        end else begin
                            beat_d     = 1'b1;
                            amp_d      = mx_cur - mn_cur;
                            thr_d      = mid_sum[BITS:1];
                            max_d      = sample_in;
                            min_d      = sample_in;
                            interval_d = '0;
                            if (armed_q) begin
                                div_start = !div_busy;
                                state_d   = S_DIVIDE;
                            end else begin
                                armed_d = 1'b1;
                                state_d = S_HIGH;
                            end
                        end
                    end
                end
                S_HIGH: begin
                    if (fall) state_d = S_WAIT_RISE;
                end
                S_DIVIDE: begin
                    if (div_done) begin
                        bpm_d       = bpm_new;
                        bpm_valid_d = 1'b1;
                        state_d     = S_HIGH;
                    end
                end
                default: state_d = S_WAIT_RISE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_WAIT_RISE;
            thr_q       <= THR_MID;
            armed_q     <= 1'b0;
            max_q       <= '0;
            min_q       <= '1;
            amp_q       <= '0;
            bpm_q       <= '0;
            bpm_valid_q <= 1'b0;
            beat_q      <= 1'b0;
            tick_cnt_q  <= '0;
            interval_q  <= '0;
        end else begin
            state_q     <= state_d;
            thr_q       <= thr_d;
            armed_q     <= armed_d;
            max_q       <= max_d;
            min_q       <= min_d;
            amp_q       <= amp_d;
            bpm_q       <= bpm_d;
            bpm_valid_q <= bpm_valid_d;
            beat_q      <= beat_d;
            tick_cnt_q  <= tick_cnt_d;
            interval_q  <= interval_d;
        end
    end

    always_comb begin
        BPM_estimate    = bpm_q;
        pulse_amplitude = amp_q;
        bpm_valid       = bpm_valid_q;
        beat_pulse      = beat_q;
        dbg_state       = state_q;
        dbg_armed       = armed_q;
        dbg_thr         = thr_q;
    end

endmodule

// File: tb/tb_pulse_bpm_estimator.sv
// Directed + randomized bench for pulse_bpm_estimator against an event-level reference model.
`timescale 1ns/1ps
module tb_pulse_bpm_estimator;
  import adsr_pkg::*;

  localparam int CLK_HZ = 10_000;
  localparam int CPM    = CLK_HZ / 1000;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] sample_in;
  logic       sample_valid;
  logic [7:0] bpm_estimate;
  logic [7:0] pulse_amplitude;
  logic       bpm_valid;
  logic       beat_pulse;
  state_t     dbg_state;
  logic       dbg_armed;
  logic [7:0] dbg_thr;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc;

  pulse_bpm_estimator #(.CLK_FREQ_HZ(CLK_HZ)) dut (
    .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
    .BPM_estimate(bpm_estimate), .pulse_amplitude(pulse_amplitude),
    .bpm_valid(bpm_valid), .beat_pulse(beat_pulse),
    .dbg_state(dbg_state), .dbg_armed(dbg_armed), .dbg_thr(dbg_thr)
  );

  // clock / reset / edge counter
  always #5 clk = ~clk;
  always @(posedge clk or posedge reset)
    if (reset) cyc <= 0;
    else cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: run did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  // reference model: beats, intervals and outputs from the behavioural rules
  int m_thr, m_armed, m_max, m_min, m_bpm, m_valid, m_amp, m_high;
  int m_clr, m_to_done, m_div_edge, m_div_val;

  task automatic model_reset();
    m_thr = 128; m_armed = 0; m_max = 0; m_min = 255;
    m_bpm = 0; m_valid = 0; m_amp = 0; m_high = 0;
    m_clr = 0; m_to_done = 0; m_div_edge = -1; m_div_val = 0;
  endtask

  // ms elapsed since the last clear, as seen just before edge n
  function automatic int ival_at(int n);
    int v;
    v = (n - 1) / CPM - m_clr / CPM;
    return (v > 1500) ? 1500 : v;
  endfunction

  function automatic int timeout_edge();
    return (m_clr / CPM + 1500) * CPM;
  endfunction

  task automatic apply_timeout();
    m_bpm = 0; m_amp = 0; m_valid = 0; m_armed = 0;
    m_thr = 128; m_high = 0; m_to_done = 1;
  endtask

  task automatic model_sync(input int n);
    int raw;
    if (m_div_edge >= 0 && m_div_edge <= n) begin
      raw = 60000 / m_div_val;
      if (raw < 40) raw = 40;
      if (raw > 200) raw = 200;
`ifdef BPM_SMOOTH_EN
      if (m_valid == 1) raw = (3 * m_bpm + raw + 2) / 4;
`endif
      m_bpm = raw; m_valid = 1; m_high = 1; m_div_edge = -1;
    end
    if (m_to_done == 0 && timeout_edge() <= n) apply_timeout();
  endtask

  task automatic model_sample(input int n, input int v, output bit beat);
    int mx, mn, hi, lo, iv;
    beat = 0;
    model_sync(n - 1);
    mx = (v > m_max) ? v : m_max;
    mn = (v < m_min) ? v : m_min;
    if (m_to_done == 0 && timeout_edge() == n) begin
      apply_timeout();
    end else if (m_div_edge >= 0) begin
      // divider still running: trackers only
    end else if (m_high == 0) begin
      hi = (m_thr + 8 > 255) ? 255 : m_thr + 8;
      if (v > hi) begin
        iv = ival_at(n);
        if (iv < 300) begin
          m_high = 1;
        end else begin
          beat = 1;
          m_amp = mx - mn;
          m_thr = (mx + mn) / 2;
          mx = v; mn = v;
          m_clr = n; m_to_done = 0;
          if (m_armed == 1) begin
            m_div_val = iv; m_div_edge = n + 17;
          end else begin
            m_armed = 1; m_high = 1;
          end
        end
      end
    end else begin
      lo = (m_thr >= 8) ? m_thr - 8 : 0;
      if (v < lo) m_high = 0;
    end
    m_max = mx; m_min = mn;
  endtask

  // scoreboard
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input bit exp_beat);
    state_t es;
    model_sync(cyc);
    es = (m_div_edge >= 0) ? S_DIVIDE : ((m_high == 1) ? S_HIGH : S_WAIT_RISE);
    chk({tag, ".beat"},  32'(beat_pulse),      32'(exp_beat));
    chk({tag, ".bpm"},   32'(bpm_estimate),    32'(m_bpm));
    chk({tag, ".valid"}, 32'(bpm_valid),       32'(m_valid));
    chk({tag, ".amp"},   32'(pulse_amplitude), 32'(m_amp));
    chk({tag, ".thr"},   32'(dbg_thr),         32'(m_thr));
    chk({tag, ".armed"}, 32'(dbg_armed),       32'(m_armed));
    chk({tag, ".state"}, 32'(dbg_state),       32'(es));
  endtask

  // driver tasks
  task automatic wait_until_ms(input int ms);
    while (cyc < ms * CPM) @(posedge clk);
  endtask

  task automatic send(input int v, input string tag);
    bit b;
    @(posedge clk); #1;
    sample_in = 8'(v); sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    model_sample(cyc, v, b);
    check_outputs(tag, b);
  endtask

  task automatic settle(input string tag);
    repeat (17) @(posedge clk);
    #1;
    check_outputs(tag, 1'b0);
  endtask

  initial begin
    int t, p, lo, hi;
    reset = 1'b1; sample_in = '0; sample_valid = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset", 1'b0);
    reset = 1'b0;

    wait_until_ms(10);
    #1;
    check_outputs("idle", 1'b0);

    // square wave 20/220 rising every 750 ms
    wait_until_ms(375);  send(20, "sq_lo0");
    wait_until_ms(750);  send(220, "sq_arm");
    chk("arm.armed", 32'(dbg_armed), 32'd1);
    settle("arm_settle");
    chk("arm.nobpm", 32'(bpm_valid), 32'd0);
    wait_until_ms(1125); send(20, "sq_lo1");
    wait_until_ms(1500); send(220, "sq_beat");
    chk("beat.amp", 32'(pulse_amplitude), 32'd200);
    chk("beat.thr", 32'(dbg_thr), 32'd120);
    repeat (16) @(posedge clk);
    #1;
    chk("div16.valid", 32'(bpm_valid), 32'd0);
    @(posedge clk); #1;
    chk("div17.valid", 32'(bpm_valid), 32'd1);
    chk("div17.bpm", 32'(bpm_estimate), 32'd80);
    check_outputs("div17", 1'b0);

    // rise 200 ms after the accepted beat is refractory
    wait_until_ms(1600); send(20, "ref_lo");
    wait_until_ms(1700); send(220, "refract");
    chk("refract.beat", 32'(beat_pulse), 32'd0);
    chk("refract.state", 32'(dbg_state), 32'(S_HIGH));
    chk("refract.bpm", 32'(bpm_estimate), 32'd80);

    // asynchronous reset five cycles into the divide
    wait_until_ms(1900); send(20, "rst_lo");
    wait_until_ms(2250); send(220, "rst_beat");
    repeat (5) @(posedge clk);
    #1;
    chk("pre_rst.state", 32'(dbg_state), 32'(S_DIVIDE));
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs("async_rst", 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    check_outputs("post_rst", 1'b0);

    // timeout after an accepted beat
    wait_until_ms(200);  send(20, "to_lo0");
    wait_until_ms(500);  send(220, "to_arm");
    wait_until_ms(800);  send(20, "to_lo1");
    wait_until_ms(1100); send(220, "to_beat");
    settle("to_settle");
    chk("to_bpm100", 32'(bpm_estimate), 32'd100);
    wait_until_ms(1300); send(20, "to_lo2");
    wait_until_ms(2700); #1;
    check_outputs("timeout", 1'b0);
    chk("timeout.bpm", 32'(bpm_estimate), 32'd0);
    chk("timeout.amp", 32'(pulse_amplitude), 32'd0);
    chk("timeout.valid", 32'(bpm_valid), 32'd0);
    wait_until_ms(2800); send(220, "rearm");
    settle("rearm_settle");
    chk("rearm.valid", 32'(bpm_valid), 32'd0);

    // randomized beat train
    t = 2800;
    for (int i = 0; i < 4; i++) begin
      p  = $urandom_range(250, 600);
      lo = $urandom_range(0, 60);
      hi = $urandom_range(190, 255);
      wait_until_ms(t + p / 2); send(lo, "rnd_lo");
      wait_until_ms(t + p);     send(hi, "rnd_hi");
      settle("rnd_settle");
      t = t + p;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pulse_bpm_estimator.md
# pulse_bpm_estimator

Front-end stage that turns the raw pulse-sensor sample stream into the `BPM_estimate` and `pulse_amplitude` control values consumed by the ADSR pixel filter. It detects beats with an adaptive hysteresis threshold and measures the beat-to-beat interval in milliseconds. It converts that interval to BPM with a serial divider and tracks peak-to-trough amplitude. It sits between the sensor ADC sampler and the ADSR filter's control inputs.

## Interface
- `CLK_FREQ_HZ`, 50_000_000: clock frequency; ms tick period = CLK_FREQ_HZ/1000 cycles
- `BITS`, 8: sample and amplitude width
- `MIN_BPM`, 40: lower BPM bound; timeout interval = 60000/MIN_BPM ms (1500)
- `MAX_BPM`, 200: upper BPM bound; refractory interval = 60000/MAX_BPM ms (300)
- `HYST`, 8: threshold hysteresis in sample LSBs
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high reset
- `sample_in`  in  BITS  sensor sample, unsigned
- `sample_valid`  in  1  one-cycle strobe qualifying `sample_in`
- `BPM_estimate`  out  $clog2(MAX_BPM+1)  current BPM, 0 when invalid
- `pulse_amplitude`  out  BITS  max−min of last accepted beat period
- `bpm_valid`  out  1  BPM_estimate holds a measured value
- `beat_pulse`  out  1  one-cycle strobe per accepted beat

## Operation
- Reset: all outputs 0. State `S_WAIT_RISE`. `thr`=2^(BITS−1) (128). `armed`=0. Interval, tick counter and max/min trackers cleared; max=0, min=2^BITS−1.
- ms tick: counter wraps at CLK_FREQ_HZ/1000−1. `interval_ms` (11 bits) increments per tick and saturates at the timeout value.
- Trackers: every `sample_valid` updates max/min in every state.
- Comparisons are done at BITS+1 width. `thr+HYST` saturates at 2^BITS−1 and `thr−HYST` floors at 0.
- `S_WAIT_RISE`: `sample_valid && sample_in > thr+HYST` → rise.
  - If `interval_ms < 300`: refractory. Go to `S_HIGH`; nothing else changes.
  - Else: assert `beat_pulse`. Set `pulse_amplitude` = max−min. Set `thr` = (max+min)>>1. Both use max/min including the detecting sample. Reset max/min to the current sample and clear `interval_ms`.
  - If `armed`=1: latch the interval into the divider and go to `S_DIVIDE`.
  - Else: set `armed`=1, do not update BPM, and go to `S_HIGH`.
- `S_DIVIDE`: restoring divide 60000 / interval, 16 iterations, one per cycle. The quotient is truncated and clamped to [MIN_BPM, MAX_BPM]. On completion, write BPM (raw, or smoothed per Configuration) and set `bpm_valid`=1 → `S_HIGH`. Threshold comparisons are ignored while in this state.
- `S_HIGH`: `sample_valid && sample_in < thr−HYST` → `S_WAIT_RISE`.
- Timeout: when `interval_ms` reaches 1500 in any state other than `S_DIVIDE`:
  - `BPM_estimate`=0, `pulse_amplitude`=0, `bpm_valid`=0, `armed`=0.
  - `thr` back to midscale; go to `S_WAIT_RISE`.
  - Timeout and rise on the same cycle: timeout wins.
- Interval resets on every accepted beat, so timeout cannot occur in `S_DIVIDE`.

## Timing
- `beat_pulse` is registered: high for exactly the one cycle after the edge sampling the detecting sample.
- `BPM_estimate` and `bpm_valid` update 17 edges after that detecting edge: 1 load + 16 iterations.
- `pulse_amplitude` updates at the same time as `beat_pulse`.
- Samples arrive far slower than 17 cycles. A `sample_valid` during `S_DIVIDE` only updates the trackers.
- Asynchronous reset at any point, including mid-divide, forces reset values immediately. The divider result is discarded.

## Configuration
- `BPM_SMOOTH_EN` defined: on a write with `bpm_valid`=1, BPM = (3·prev + new + 2)>>2, computed at 10-bit width. If `bpm_valid`=0 the raw value is written.
- Undefined: the raw clamped quotient is written every time; no smoothing registers exist.

## Structure
- Shared package `adsr_pkg` holds:
  - the state typedef (`S_WAIT_RISE`, `S_HIGH`, `S_DIVIDE`)
  - `MS_PER_MIN` = 60000
  - helpers for the refractory and timeout constants
- Sub-module `bpm_serial_div` is a 16-bit restoring divider with ports `start`, `dividend`, `divisor`, `busy`, `done`, `quotient`. It has a 16-cycle latency and a one-cycle `done`.

## Test plan
- Reset, then idle → all outputs 0, `bpm_valid`=0, no `beat_pulse`.
- CLK_FREQ_HZ=10_000, square wave 20/220, rising every 750 ms, no smoothing:
  - first rise only sets `armed`;
  - second rise gives `beat_pulse`, `pulse_amplitude`=200, `thr`=120, and 17 edges later `BPM_estimate`=80, `bpm_valid`=1.
- Rise 200 ms after an accepted beat → no `beat_pulse`, BPM unchanged, state `S_HIGH`.
- No rise for 1500 ms after an accepted beat:
  - `BPM_estimate`=0, `pulse_amplitude`=0, `bpm_valid`=0;
  - the next rise arms only, with no BPM update.
- `BPM_SMOOTH_EN`, previous 80, next interval 500 ms (raw 120) → `BPM_estimate`=90.
- Reset asserted 5 cycles into `S_DIVIDE` → outputs 0 in the same cycle; after release the state is `S_WAIT_RISE` and `armed`=0.
